jump_game_ctrl: RTL and testbench
=================================

Name: jump_game_ctrl

Overview:
- Sequences one jump of the press-to-jump game: charge, flight, landing check, scoring, game-over.
- Sits between the debounced key input and the VGA display/animation datapath.
- Produces the press-duration value, the in-press flag and per-frame flight step strobes that the datapath consumes.
- Collects landing results back from the datapath and keeps the BCD score shown on the 7-segment driver.

Parameters:
- CHARGE_DIV, 8, frame ticks per press_time increment while charging.
- LAND_TIMEOUT, 1023, clk cycles to wait in LAND for a landing result.
- RESTART_FRAMES, 60, frame ticks the key must be held in OVER to request a restart.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- frame_tick  in  1  one-cycle strobe, once per video frame
- key_down  in  1  debounced jump key level
- score_signal  in  1  one-cycle landing-success pulse from datapath
- get_score  in  4  points for this landing, valid with score_signal
- end_game_in  in  1  landing-failure level from datapath
- is_pressing  out  1  high during CHARGE
- press_time  out  4  charge count; latched at release
- step_en  out  1  one-cycle flight-step strobe
- flight_left  out  4  remaining flight steps
- score_bcd  out  16  4-digit BCD score
- game_over  out  1  high in OVER
- restart_req  out  1  one-cycle restart pulse to the datapath reset mux
- state  out  3  FSM state, for debug LEDs

Behaviour:
- Reset values (async, while rst=1):
  - state=IDLE; all outputs 0.
  - Internal key_down edge register = 1, so a key held through reset does not trigger a jump.
- States: IDLE=0, CHARGE=1, FLIGHT=2, LAND=3, OVER=4.
- IDLE: rising edge of key_down (registered compare) -> CHARGE next cycle.
  - Also on entering CHARGE: press_time=0, divider=0, is_pressing=1.
- CHARGE:
  - Each frame_tick increments the divider.
  - When the divider reaches CHARGE_DIV-1 it wraps to 0 and press_time increments, saturating at 15.
  - key_down=0 -> leave CHARGE and clear is_pressing.
  - If press_time=0 at release, go to IDLE (no jump). Otherwise go to FLIGHT with flight_left=press_time.
  - Release and frame_tick in the same cycle: release wins; the tick is not counted.
- FLIGHT:
  - Each frame_tick: step_en=1 for that cycle, flight_left decrements.
  - When flight_left reaches 0 (same cycle as the last step_en) -> LAND; timeout counter cleared.
  - key_down is ignored. press_time holds its latched value.
- LAND: evaluate in priority order.
  1. end_game_in=1 -> OVER. This wins over a simultaneous score_signal; no score is added.
  2. score_signal=1 -> score_bcd += get_score -> IDLE.
  3. Counter reaches LAND_TIMEOUT -> IDLE, score unchanged.
- Score arithmetic:
  - 4-digit BCD add with per-digit decimal carry.
  - get_score above 9 is clamped to 9.
  - Saturates at 9999; no wrap.
- OVER:
  - game_over=1.
  - Counts frame_ticks while key_down=1; any release clears the count.
  - Count reaching RESTART_FRAMES -> restart_req pulses for 1 cycle, score_bcd=0, -> IDLE.
  - In IDLE after a restart, a new jump needs a fresh rising edge.
- score_signal outside LAND is ignored. end_game_in outside LAND is ignored except in OVER, where it has no effect.
- rst asserted mid-jump aborts immediately to the reset values; no step_en is issued after rst rises.
- Latency:
  - key edge -> is_pressing: 1 cycle.
  - Release -> first possible step_en: the next frame_tick after entering FLIGHT.

Decomposition:
- Shared package: state encodings (IDLE..OVER), BCD digit max 4'd9, score max 16'h9999.
- Sub-module: bcd_add4 (16-bit BCD + 4-bit binary digit, saturating), combinational, reusable by the 7-segment path.
- FSM, divider, flight counter and timeout counter stay in the top module.

Test Plan:
- Press for 40 frame_ticks with CHARGE_DIV=8, then release -> press_time=5, flight_left=5; exactly 5 step_en pulses, one per tick; then state=LAND.
- Press for 200 ticks -> press_time saturates at 15; 15 step_en pulses.
- Press and release within 3 ticks -> press_time=0, return to IDLE, no step_en.
- In LAND with score_bcd=16'h0098, score_signal with get_score=5 -> score_bcd=16'h0103, state=IDLE. With score_bcd=16'h9997 and get_score=4 -> 16'h9999.
- In LAND, score_signal and end_game_in asserted together -> OVER, score unchanged, game_over=1. Hold key 60 ticks -> one restart_req pulse, score_bcd=0, IDLE. Release at tick 30 and re-press -> count restarts from 0.
- Assert rst during FLIGHT with flight_left=7 -> all outputs 0 immediately. Key still held after rst falls -> stays IDLE until release and re-press.

Source files
------------

// File: rtl/jump_game_ctrl_pkg.sv
// Shared encodings and BCD helpers for the press-to-jump game controller.
package jump_game_ctrl_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CHARGE = 3'd1;
    localparam logic [2:0] ST_FLIGHT = 3'd2;
    localparam logic [2:0] ST_LAND   = 3'd3;
    localparam logic [2:0] ST_OVER   = 3'd4;

    localparam logic [3:0]  BCD_DIGIT_MAX = 4'd9;
    localparam logic [15:0] SCORE_MAX     = 16'h9999;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t d3;
        bcd_digit_t d2;
        bcd_digit_t d1;
        bcd_digit_t d0;
    } bcd_score_t;

    function automatic bcd_digit_t clampDigit(input logic [3:0] value);
        return (value > BCD_DIGIT_MAX) ? BCD_DIGIT_MAX : value;
    endfunction

endpackage

// File: rtl/jump_game_ctrl_bcd_add4.sv
// Adds one binary point value (clamped to a single decimal digit) to a
// 4-digit BCD score, saturating at 9999 instead of wrapping.
module bcd_add4
    import jump_game_ctrl_pkg::*;
(
    input  logic [15:0] i_bcd,
    input  logic [3:0]  i_digit,
    output logic [15:0] o_sum
);

    logic [4:0]  w_acc;
    logic        w_carry;
    logic [15:0] w_raw;

    // Ripple the decimal carry digit by digit; a carry out of the top digit means overflow.
    always_comb begin
        w_acc   = 5'd0;
        w_carry = 1'b0;
        w_raw   = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            w_acc = {1'b0, i_bcd[i*4 +: 4]} + {4'b0000, w_carry};
            if (i == 0) begin
                w_acc = w_acc + {1'b0, clampDigit(i_digit)};
            end
            if (w_acc > 5'd9) begin
                w_raw[i*4 +: 4] = 4'(w_acc - 5'd10);
                w_carry         = 1'b1;
            end else begin
                w_raw[i*4 +: 4] = w_acc[3:0];
                w_carry         = 1'b0;
            end
        end
        o_sum = w_carry ? SCORE_MAX : w_raw;
    end

endmodule

// File: rtl/jump_game_ctrl.sv
// Jump sequencer: charge on key hold, step the flight once per frame,
// collect the landing result, keep the BCD score and handle game-over restart.
module jump_game_ctrl
    import jump_game_ctrl_pkg::*;
#(
    parameter int CHARGE_DIV     = 8,
    parameter int LAND_TIMEOUT   = 1023,
    parameter int RESTART_FRAMES = 60
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_frame_tick,
    input  logic        i_key_down,
    input  logic        i_score_signal,
    input  logic [3:0]  i_get_score,
    input  logic        i_end_game_in,
    output logic        o_is_pressing,
    output logic [3:0]  o_press_time,
    output logic        o_step_en,
    output logic [3:0]  o_flight_left,
    output logic [15:0] o_score_bcd,
    output logic        o_game_over,
    output logic        o_restart_req,
    output logic [2:0]  o_state
);

    localparam int DIV_W = (CHARGE_DIV > 1) ? $clog2(CHARGE_DIV) : 1;
    localparam int TO_W  = $clog2(LAND_TIMEOUT + 1);
    localparam int RS_W  = (RESTART_FRAMES > 1) ? $clog2(RESTART_FRAMES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CHARGE_DIV - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LAND_TIMEOUT);
    localparam logic [RS_W-1:0]  RS_LAST  = RS_W'(RESTART_FRAMES - 1);

    logic [2:0]       r_state;
    logic             r_key_prev;
    logic [3:0]       r_press_time;
    logic [DIV_W-1:0] r_div;
    logic [3:0]       r_flight_left;
    logic [TO_W-1:0]  r_timeout;
    logic [RS_W-1:0]  r_restart_cnt;
    logic             r_step_en;
    logic             r_restart_req;
    logic [15:0]      r_score;

    logic             w_key_rise;
    logic [15:0]      w_score_next;

    assign w_key_rise = i_key_down & ~r_key_prev;

    bcd_add4 u_bcd_add4 (
        .i_bcd   (r_score),
        .i_digit (i_get_score),
        .o_sum   (w_score_next)
    );

    // The edge register resets high so a key held through reset never looks like a fresh press.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_key_prev    <= 1'b1;
            r_press_time  <= 4'd0;
            r_div         <= '0;
            r_flight_left <= 4'd0;
            r_timeout     <= '0;
            r_restart_cnt <= '0;
            r_step_en     <= 1'b0;
            r_restart_req <= 1'b0;
            r_score       <= 16'h0000;
        end else begin
            r_key_prev    <= i_key_down;
            r_step_en     <= 1'b0;
            r_restart_req <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_key_rise) begin
                        r_state      <= ST_CHARGE;
                        r_press_time <= 4'd0;
                        r_div        <= '0;
                    end
                end
                ST_CHARGE: begin
                    // Release is checked first so a coincident tick is dropped.
                    if (!i_key_down) begin
                        if (r_press_time == 4'd0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state       <= ST_FLIGHT;
                            r_flight_left <= r_press_time;
                        end
                    end else if (i_frame_tick) begin
                        if (r_div == DIV_LAST) begin
                            r_div <= '0;
                            if (r_press_time != 4'd15) begin
                                r_press_time <= r_press_time + 4'd1;
                            end
                        end else begin
                            r_div <= r_div + DIV_W'(1);
                        end
                    end
                end
                ST_FLIGHT: begin
                    if (i_frame_tick) begin
                        r_step_en     <= 1'b1;
                        r_flight_left <= r_flight_left - 4'd1;
                        if (r_flight_left == 4'd1) begin
                            r_state   <= ST_LAND;
                            r_timeout <= '0;
                        end
                    end
                end
                ST_LAND: begin
                    if (i_end_game_in) begin
                        r_state       <= ST_OVER;
                        r_restart_cnt <= '0;
                    end else if (i_score_signal) begin
                        r_score <= w_score_next;
                        r_state <= ST_IDLE;
                    end else if (r_timeout == TO_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_timeout <= r_timeout + TO_W'(1);
                    end
                end
                ST_OVER: begin
                    if (!i_key_down) begin
                        r_restart_cnt <= '0;
                    end else if (i_frame_tick) begin
                        if (r_restart_cnt == RS_LAST) begin
                            r_restart_cnt <= '0;
                            r_restart_req <= 1'b1;
                            r_score       <= 16'h0000;
                            r_state       <= ST_IDLE;
                        end else begin
                            r_restart_cnt <= r_restart_cnt + RS_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_is_pressing = (r_state == ST_CHARGE);
    assign o_game_over   = (r_state == ST_OVER);
    assign o_press_time  = r_press_time;
    assign o_step_en     = r_step_en;
    assign o_flight_left = r_flight_left;
    assign o_score_bcd   = r_score;
    assign o_restart_req = r_restart_req;
    assign o_state       = r_state;

endmodule

// File: tb/tb_jump_game_ctrl.sv
// Directed bench for jump_game_ctrl: table-driven jump lengths plus
// hand-written scoring, game-over/restart, timeout and reset sequences.
module tb_jump_game_ctrl;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHARGE = 3'd1;
    localparam logic [2:0] S_FLIGHT = 3'd2;
    localparam logic [2:0] S_LAND   = 3'd3;
    localparam logic [2:0] S_OVER   = 3'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        key_down;
    logic        score_signal;
    logic [3:0]  get_score;
    logic        end_game_in;
    logic        is_pressing;
    logic [3:0]  press_time;
    logic        step_en;
    logic [3:0]  flight_left;
    logic [15:0] score_bcd;
    logic        game_over;
    logic        restart_req;
    logic [2:0]  state;

    int assertCount  = 0;
    int failCount    = 0;
    int stepCount    = 0;
    int restartCount = 0;

    typedef struct {
        int         ticks;
        logic [3:0] expPress;
        int         expSteps;
    } jumpVec_t;

    jumpVec_t jumpTab [6];

    jump_game_ctrl dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_frame_tick   (frame_tick),
        .i_key_down     (key_down),
        .i_score_signal (score_signal),
        .i_get_score    (get_score),
        .i_end_game_in  (end_game_in),
        .o_is_pressing  (is_pressing),
        .o_press_time   (press_time),
        .o_step_en      (step_en),
        .o_flight_left  (flight_left),
        .o_score_bcd    (score_bcd),
        .o_game_over    (game_over),
        .o_restart_req  (restart_req),
        .o_state        (state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (step_en) stepCount++;
        if (restart_req) restartCount++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyTicks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Full jump with a given hold length; lands with zero points so the score is untouched.
    task automatic applyStimulus(input jumpVec_t v);
        int base;
        key_down = 1'b1;
        @(negedge clk);
        checkOutput("charge_state", 32'(state), 32'(S_CHARGE));
        checkOutput("charge_is_pressing", 32'(is_pressing), 32'd1);
        applyTicks(v.ticks);
        key_down = 1'b0;
        @(negedge clk);
        base = stepCount;
        checkOutput("release_is_pressing", 32'(is_pressing), 32'd0);
        checkOutput("release_press_time", 32'(press_time), 32'(v.expPress));
        if (v.expPress != 4'd0) begin
            checkOutput("release_state", 32'(state), 32'(S_FLIGHT));
            checkOutput("release_flight_left", 32'(flight_left), 32'(v.expPress));
            for (int k = 0; k < 40 && state != S_LAND; k++) begin
                applyTicks(1);
            end
            @(negedge clk);
            checkOutput("flight_steps", 32'(stepCount - base), 32'(v.expSteps));
            checkOutput("flight_end_state", 32'(state), 32'(S_LAND));
            checkOutput("flight_end_left", 32'(flight_left), 32'd0);
            score_signal = 1'b1;
            get_score    = 4'd0;
            @(negedge clk);
            score_signal = 1'b0;
            @(negedge clk);
            checkOutput("land_zero_state", 32'(state), 32'(S_IDLE));
        end else begin
            checkOutput("short_press_state", 32'(state), 32'(S_IDLE));
            applyTicks(3);
            @(negedge clk);
            checkOutput("short_press_steps", 32'(stepCount - base), 32'd0);
        end
    endtask

    // Minimum jump (8 ticks -> press_time 1, one step) ending in LAND.
    task automatic jumpToLand();
        key_down = 1'b1;
        @(negedge clk);
        frame_tick = 1'b1;
        repeat (8) @(negedge clk);
        frame_tick = 1'b0;
        key_down   = 1'b0;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic scoreLand(input logic [3:0] g);
        score_signal = 1'b1;
        get_score    = g;
        @(negedge clk);
        score_signal = 1'b0;
        @(negedge clk);
    endtask

    task automatic quickLand(input logic [3:0] g);
        jumpToLand();
        scoreLand(g);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_state"}, 32'(state), 32'd0);
        checkOutput({tag, "_is_pressing"}, 32'(is_pressing), 32'd0);
        checkOutput({tag, "_press_time"}, 32'(press_time), 32'd0);
        checkOutput({tag, "_step_en"}, 32'(step_en), 32'd0);
        checkOutput({tag, "_flight_left"}, 32'(flight_left), 32'd0);
        checkOutput({tag, "_score"}, 32'(score_bcd), 32'd0);
        checkOutput({tag, "_game_over"}, 32'(game_over), 32'd0);
        checkOutput({tag, "_restart_req"}, 32'(restart_req), 32'd0);
    endtask

    initial begin
        int base;
        jumpTab[0] = '{ticks: 40,  expPress: 4'd5,  expSteps: 5};
        jumpTab[1] = '{ticks: 200, expPress: 4'd15, expSteps: 15};
        jumpTab[2] = '{ticks: 3,   expPress: 4'd0,  expSteps: 0};
        jumpTab[3] = '{ticks: 8,   expPress: 4'd1,  expSteps: 1};
        jumpTab[4] = '{ticks: 7,   expPress: 4'd0,  expSteps: 0};
        jumpTab[5] = '{ticks: 17,  expPress: 4'd2,  expSteps: 2};

        rst          = 1'b1;
        key_down     = 1'b1;
        frame_tick   = 1'b0;
        score_signal = 1'b0;
        get_score    = 4'd0;
        end_game_in  = 1'b0;
        waitCycles(3);
        checkAllZero("reset");

        // Key held through reset must not start a jump.
        rst = 1'b0;
        waitCycles(3);
        checkOutput("held_key_after_reset", 32'(state), 32'(S_IDLE));
        key_down = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(jumpTab[i]);
        end
        checkOutput("score_after_table", 32'(score_bcd), 32'h0000);

        quickLand(4'd12);
        checkOutput("score_clamp", 32'(score_bcd), 32'h0009);
        repeat (9) quickLand(4'd9);
        quickLand(4'd8);
        checkOutput("score_0098", 32'(score_bcd), 32'h0098);
        quickLand(4'd5);
        checkOutput("score_0103", 32'(score_bcd), 32'h0103);
        checkOutput("score_0103_state", 32'(state), 32'(S_IDLE));

        jumpToLand();
        checkOutput("land_before_end", 32'(state), 32'(S_LAND));
        score_signal = 1'b1;
        end_game_in  = 1'b1;
        get_score    = 4'd5;
        @(negedge clk);
        score_signal = 1'b0;
        end_game_in  = 1'b0;
        checkOutput("end_wins_state", 32'(state), 32'(S_OVER));
        checkOutput("end_wins_game_over", 32'(game_over), 32'd1);
        checkOutput("end_wins_score", 32'(score_bcd), 32'h0103);

        // 30 held ticks then a release must discard the partial restart count.
        base = restartCount;
        key_down = 1'b1;
        @(negedge clk);
        applyTicks(30);
        key_down = 1'b0;
        @(negedge clk);
        key_down = 1'b1;
        @(negedge clk);
        applyTicks(59);
        checkOutput("over_after_59", 32'(state), 32'(S_OVER));
        checkOutput("no_early_restart", 32'(restartCount - base), 32'd0);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        checkOutput("restart_pulse", 32'(restart_req), 32'd1);
        checkOutput("restart_state", 32'(state), 32'(S_IDLE));
        checkOutput("restart_score", 32'(score_bcd), 32'h0000);
        checkOutput("restart_game_over", 32'(game_over), 32'd0);
        @(negedge clk);
        checkOutput("restart_pulse_width", 32'(restart_req), 32'd0);
        @(negedge clk);
        checkOutput("restart_count", 32'(restartCount - base), 32'd1);

        waitCycles(5);
        applyTicks(3);
        checkOutput("held_after_restart", 32'(state), 32'(S_IDLE));
        key_down = 1'b0;
        @(negedge clk);
        key_down = 1'b1;
        @(negedge clk);
        checkOutput("repress_after_restart", 32'(state), 32'(S_CHARGE));
        key_down = 1'b0;
        @(negedge clk);
        checkOutput("repress_release_idle", 32'(state), 32'(S_IDLE));

        repeat (1110) quickLand(4'd9);
        quickLand(4'd7);
        checkOutput("score_9997", 32'(score_bcd), 32'h9997);
        quickLand(4'd4);
        checkOutput("score_sat_9999", 32'(score_bcd), 32'h9999);
        quickLand(4'd9);
        checkOutput("score_hold_9999", 32'(score_bcd), 32'h9999);

        jumpToLand();
        waitCycles(500);
        checkOutput("timeout_wait_land", 32'(state), 32'(S_LAND));
        for (int k = 0; k < 1000 && state != S_IDLE; k++) begin
            @(negedge clk);
        end
        checkOutput("timeout_idle", 32'(state), 32'(S_IDLE));
        checkOutput("timeout_score", 32'(score_bcd), 32'h9999);

        key_down = 1'b1;
        @(negedge clk);
        applyTicks(56);
        key_down = 1'b0;
        @(negedge clk);
        checkOutput("pre_rst_state", 32'(state), 32'(S_FLIGHT));
        checkOutput("pre_rst_flight_left", 32'(flight_left), 32'd7);
        key_down   = 1'b1;
        frame_tick = 1'b1;
        rst        = 1'b1;
        #1;
        checkAllZero("midflight_rst");
        base = stepCount;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        applyTicks(4);
        checkOutput("post_rst_steps", 32'(stepCount - base), 32'd0);
        checkOutput("post_rst_held_idle", 32'(state), 32'(S_IDLE));
        key_down = 1'b0;
        @(negedge clk);
        key_down = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_repress", 32'(state), 32'(S_CHARGE));
        key_down = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_release", 32'(state), 32'(S_IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
